// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer for the Fetch stage.
// Drives a synchronous-read instruction memory (1-cycle latency, no enable)
// and hands (pc, instruction) pairs to IF/ID over a valid/ready handshake.
// A downstream stall captures the in-flight word; a redirect squashes the wrong path.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   mem_addr       word index into instruction memory, {2'b00, pc[31:2]} (register-driven)
//   mem_data       read data for the mem_addr presented in the previous cycle
//   redirect_valid one-cycle pulse restarting fetch at redirect_pc
//   redirect_pc    redirect target byte address (bits [1:0] ignored)
//   out_valid      out_instr/out_pc are valid
//   out_ready      IF/ID accepts this cycle
//   out_instr      fetched instruction
//   out_pc         byte address of out_instr
//   fetch_count    (FETCH_PERF_CNT_EN only) number of completed transfers
//   stall_count    (FETCH_PERF_CNT_EN only) number of cycles with out_valid && !out_ready
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the two performance counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  typedef enum logic {FETCH, STALL} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, rsp_pc, rsp_pc_n, hold_instr, hold_n;
  logic        rsp_valid, rsp_valid_n;
  logic        advance;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC & ~32'd3;
      rsp_pc     <= '0;
      rsp_valid  <= 1'b0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      rsp_pc     <= rsp_pc_n;
      rsp_valid  <= rsp_valid_n;
      hold_instr <= hold_n;
    end
  end
  // In STALL the held pc has already been on mem_addr for at least one cycle,
  // so releasing the stall can issue it exactly as a normal FETCH advance does.
  assign advance = (state == STALL) ? out_ready : (!rsp_valid || out_ready);
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    rsp_pc_n    = rsp_pc;
    rsp_valid_n = rsp_valid;
    hold_n      = hold_instr;
    if (redirect_valid) begin
      pc_n        = {redirect_pc[31:2], 2'b00};
      rsp_valid_n = 1'b0;
      state_n     = FETCH;
    end else if (advance) begin
      rsp_pc_n    = pc;
      rsp_valid_n = 1'b1;
      pc_n        = pc + 32'd4;
      state_n     = FETCH;
    end else if (state == FETCH) begin
      hold_n  = mem_data;
      state_n = STALL;
    end
  end
  assign mem_addr  = {2'b00, pc[31:2]};
  assign out_valid = (state == STALL) || rsp_valid;
  assign out_instr = (state == STALL) ? hold_instr : mem_data;
  assign out_pc    = rsp_pc;
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      fetch_count <= fetch_count + {31'd0, out_valid && out_ready};
      stall_count <= stall_count + {31'd0, out_valid && !out_ready};
    end
  end
`endif
endmodule
